sipo_ctrl: RTL and testbench

//  Sequencer for the serial-in/parallel-out loader. It accepts one load command at a time from the PMU host interface
//  and drives the loader's en/send/instruction controls. It counts serial bits, and for the memory-to-AES path it

---
 rtl/sipo_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_sipo_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_ctrl.sv
// sipo_ctrl: command sequencer for the serial-in/parallel-out loader.
// Takes one load command from the PMU host at a time, counts serial bits
// or fetches NV-memory words, drives the loader controls and pulses done.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_op, cmd_addr  0 pc->chain, 1 pc->mem, 2 mem->aes, 3 pc->key
//   bit_valid         host serial bit valid on the loader data input
//   sipo_en/send      loader shift enable / parallel-capture strobe
//   sipo_instruction  loader instruction {2'b00, op}, 0 while idle
//   mem_rd_en/wr_en   NV-memory strobes (read data one cycle later)
//   mem_addr          NV-memory address
//   busy, done, error status; done/error are single-cycle pulses
//
// Build option: define SIPO_CTRL_TIMEOUT_EN to abort a stalled serial
// shift after TIMEOUT_CYCLES idle cycles with an error pulse.

module sipo_ctrl #(
    parameter int unsigned AES_DATA_WIDTH = 128,
    parameter int unsigned KEY_DATA_WIDTH = 128,
    parameter int unsigned MEM_DATA_WIDTH = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [MEM_ADDR_WIDTH-1:0] cmd_addr,
    input  logic                      bit_valid,
    output logic                      sipo_en,
    output logic                      sipo_send,
    output logic [3:0]                sipo_instruction,
    output logic                      mem_rd_en,
    output logic                      mem_wr_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    // Words per AES block on the memory-to-AES path.
    localparam int unsigned WORDS = AES_DATA_WIDTH / MEM_DATA_WIDTH;

    localparam int unsigned MAX_AK =
        (AES_DATA_WIDTH > KEY_DATA_WIDTH) ? AES_DATA_WIDTH : KEY_DATA_WIDTH;
    localparam int unsigned MAX_N =
        (MAX_AK > MEM_DATA_WIDTH) ? MAX_AK : MEM_DATA_WIDTH;

    localparam int unsigned BIT_W  = (MAX_N > 2) ? $clog2(MAX_N) : 1;
    // One extra count: FETCH spends WORDS+1 cycles (last cycle only
    // captures the final read data).
    localparam int unsigned WORD_W = $clog2(WORDS + 1);

    localparam logic [1:0] OP_CHAIN = 2'd0;
    localparam logic [1:0] OP_MEM   = 2'd1;
    localparam logic [1:0] OP_AES   = 2'd2;
    localparam logic [1:0] OP_KEY   = 2'd3;

    if ((AES_DATA_WIDTH % MEM_DATA_WIDTH) != 0 || WORDS < 1 ||
        TIMEOUT_CYCLES < 2) begin : g_param_err
        $error("sipo_ctrl: bad parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_FETCH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [1:0]                op_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [BIT_W-1:0]          bit_cnt;
    logic [WORD_W-1:0]         word_cnt;
    logic [BIT_W-1:0]          n_last;
    logic                      bit_last;
    logic                      word_rd;
    logic                      word_last;

`ifdef SIPO_CTRL_TIMEOUT_EN
    localparam int unsigned STALL_W =
        (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [STALL_W-1:0] stall_cnt;
    logic               stall_hit;

    assign stall_hit = (state == S_SHIFT) && !bit_valid &&
                       (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));
`endif

    // Index of the final serial bit for the latched op.
    always_comb begin
        n_last = BIT_W'(KEY_DATA_WIDTH - 1);
        unique case (1'b1)
            (op_q == OP_CHAIN): n_last = BIT_W'(AES_DATA_WIDTH - 1);
            (op_q == OP_MEM):   n_last = BIT_W'(MEM_DATA_WIDTH - 1);
            default:            n_last = BIT_W'(KEY_DATA_WIDTH - 1);
        endcase
    end

    assign bit_last  = bit_valid && (bit_cnt == n_last);
    assign word_rd   = (word_cnt < WORD_W'(WORDS));
    assign word_last = (word_cnt == WORD_W'(WORDS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            state <= state_nx;

            if (state == S_IDLE && cmd_valid) begin
                op_q   <= cmd_op;
                addr_q <= cmd_addr;
            end

            if (state != S_SHIFT) begin
                bit_cnt <= '0;
            end else if (bit_valid) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state == S_FETCH) begin
                word_cnt <= word_cnt + 1'b1;
            end else begin
                word_cnt <= '0;
            end
        end
    end

`ifdef SIPO_CTRL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == S_SHIFT && !bit_valid) begin
            stall_cnt <= stall_cnt + 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end
`endif

    always_comb begin
        state_nx         = state;
        cmd_ready        = 1'b0;
        busy             = 1'b1;
        sipo_en          = 1'b0;
        sipo_send        = 1'b0;
        sipo_instruction = {2'b00, op_q};
        mem_rd_en        = 1'b0;
        mem_wr_en        = 1'b0;
        mem_addr         = '0;
        done             = 1'b0;
        error            = 1'b0;

        unique case (state)
            S_IDLE: begin
                cmd_ready        = 1'b1;
                busy             = 1'b0;
                sipo_instruction = 4'd0;
                if (cmd_valid) begin
                    state_nx = (cmd_op == OP_AES) ? S_FETCH : S_SHIFT;
                end
            end

            S_SHIFT: begin
                // Straight through so the enable lines up with data_i.
                sipo_en = bit_valid;
                if (bit_last) begin
                    sipo_send = 1'b1;
                    state_nx  = (op_q == OP_MEM) ? S_WRITE : S_DONE;
                end
`ifdef SIPO_CTRL_TIMEOUT_EN
                else if (stall_hit) begin
                    error    = 1'b1;
                    state_nx = S_IDLE;
                end
`endif
            end

            S_FETCH: begin
                // Reads go out on cycles 0..W-1; the loader shifts the
                // returned word one cycle later, on cycles 1..W.
                mem_rd_en = word_rd;
                if (word_rd) begin
                    mem_addr = addr_q + MEM_ADDR_WIDTH'(word_cnt);
                end
                sipo_en = (word_cnt != '0);
                if (word_last) begin
                    sipo_send = 1'b1;
                    state_nx  = S_DONE;
                end
            end

            S_WRITE: begin
                mem_wr_en = 1'b1;
                mem_addr  = addr_q;
                state_nx  = S_DONE;
            end

            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sipo_ctrl.sv
// tb_sipo_ctrl: scoreboard bench for sipo_ctrl.
// Expected loader/memory events are queued as commands are driven.

module tb_sipo_ctrl;

    localparam int AW = 8;
`ifdef SIPO_CTRL_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    localparam int K_RD   = 1;
    localparam int K_SEND = 2;
    localparam int K_WR   = 3;
    localparam int K_DONE = 4;
    localparam int K_ERR  = 5;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic          bit_valid;
    logic          sipo_en;
    logic          sipo_send;
    logic [3:0]    sipo_instruction;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic          busy;
    logic          done;
    logic          error;

    sipo_ctrl #(
        .AES_DATA_WIDTH(128),
        .KEY_DATA_WIDTH(128),
        .MEM_DATA_WIDTH(32),
        .MEM_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_addr        (cmd_addr),
        .bit_valid       (bit_valid),
        .sipo_en         (sipo_en),
        .sipo_send       (sipo_send),
        .sipo_instruction(sipo_instruction),
        .mem_rd_en       (mem_rd_en),
        .mem_wr_en       (mem_wr_en),
        .mem_addr        (mem_addr),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    typedef struct {
        int kind;
        int d0;
        int d1;
    } exp_t;

    exp_t sb[$];

    int n_chk;
    int n_pass;
    int cyc;
    int acc_cyc;
    int last_en_cyc;
    int en_cnt;
    int n_acc_dut;
    int n_acc_tb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic push(input int k, input int a, input int b);
        exp_t e;
        e.kind = k;
        e.d0   = a;
        e.d1   = b;
        sb.push_back(e);
    endtask

    task automatic take(input string tag, input int k,
                        input int d0, input int d1);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_unexpected"}, k, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_kind"}, k, e.kind);
        chk({tag, "_d0"}, d0, e.d0);
        chk({tag, "_d1"}, d1, e.d1);
    endtask

    // Monitor: turns DUT strobes into events and checks them in order.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sipo_en) begin
                    en_cnt++;
                    last_en_cyc = cyc;
                end
                if (mem_rd_en)
                    take("rd", K_RD, int'(mem_addr), int'(sipo_instruction));
                if (sipo_send)
                    take("send", K_SEND, en_cnt, int'(sipo_instruction));
                if (mem_wr_en)
                    take("wr", K_WR, int'(mem_addr), int'(sipo_instruction));
                if (done)
                    take("done", K_DONE, cyc - acc_cyc, en_cnt);
                if (error)
                    take("err", K_ERR, cyc - last_en_cyc, en_cnt);
                if (cmd_valid && cmd_ready) begin
                    acc_cyc = cyc;
                    en_cnt  = 0;
                    n_acc_dut++;
                end
            end
        end
    end

    function automatic int nbits(input int op);
        return (op == 1) ? 32 : 128;
    endfunction

    function automatic int gap(input int i);
        return (i % 5 == 2) ? 1 : ((i % 11 == 7) ? 3 : 0);
    endfunction

    function automatic int total(input int n, input bit gaps);
        int t = 0;
        for (int i = 0; i < n; i++) t += 1 + (gaps ? gap(i) : 0);
        return t;
    endfunction

    task automatic accept(input int op, input int addr,
                          input bit hold, output int a);
        cmd_op    = op[1:0];
        cmd_addr  = addr[AW-1:0];
        cmd_valid = 1'b1;
        a = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                a = cyc;
                break;
            end
        end
        chk("accept_seen", int'(a >= 0), 1);
        n_acc_tb++;
        @(posedge clk);
        #1;
        cmd_valid = hold;
    endtask

    task automatic shift_bits(input int n, input bit gaps, input bit tail);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat (gap(i)) begin
                    bit_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            bit_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        if (tail) begin
            @(posedge clk);
            #1;
        end
        bit_valid = 1'b0;
    endtask

    task automatic run_shift(input int op, input int addr, input bit gaps,
                             input bit tail, input bit hold, output int a);
        int n;
        int lat;
        n   = nbits(op);
        lat = total(n, gaps) + 1 + ((op == 1) ? 1 : 0);
        push(K_SEND, n, op);
        if (op == 1) push(K_WR, addr, op);
        push(K_DONE, lat, n);
        accept(op, addr, hold, a);
        shift_bits(n, gaps, tail);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle", int'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        int a2;
        n_chk = 0; n_pass = 0; cyc = 0; acc_cyc = 0;
        last_en_cyc = 0; en_cnt = 0; n_acc_dut = 0; n_acc_tb = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0;
        cmd_addr = '0; bit_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_en", int'(sipo_en), 0);
        chk("rst_send", int'(sipo_send), 0);
        chk("rst_instr", int'(sipo_instruction), 0);
        chk("rst_mem", int'({mem_rd_en, mem_wr_en}), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_flags", int'({done, error}), 0);
        @(posedge clk);
        #1;

        // op 0, back to back; bit_valid left high into the DONE cycle
        run_shift(0, 0, 1'b0, 1'b1, 1'b0, a);
        wait_idle();

        // op 1 with gaps, write at 0x10
        run_shift(1, 'h10, 1'b1, 1'b0, 1'b0, a);
        wait_idle();

        // op 2 from 0xFE; bit_valid held high must not leak into sipo_en
        push(K_RD, 'hFE, 2);
        push(K_RD, 'hFF, 2);
        push(K_RD, 'h00, 2);
        push(K_RD, 'h01, 2);
        push(K_SEND, 4, 2);
        push(K_DONE, 6, 4);
        bit_valid = 1'b1;
        accept(2, 'hFE, 1'b0, a);
        wait_idle();
        bit_valid = 1'b0;

        // op 3 with cmd_valid held: second accept only after done
        run_shift(3, 0, 1'b0, 1'b0, 1'b1, a);
        run_shift(3, 0, 1'b1, 1'b0, 1'b0, a2);
        chk("reaccept_gap", a2 - a, 130);
        wait_idle();

        // reset after 50 bits of op 0
        accept(0, 0, 1'b0, a);
        shift_bits(50, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", int'(cmd_ready), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_instr", int'(sipo_instruction), 0);
        @(posedge clk);
        #1;
        run_shift(0, 0, 1'b1, 1'b0, 1'b0, a);
        wait_idle();

`ifdef SIPO_CTRL_TIMEOUT_EN
        // stalled shift: error 16 cycles after the 10th bit
        push(K_ERR, TO, 10);
        accept(0, 0, 1'b0, a);
        shift_bits(10, 1'b0, 1'b0);
        wait_idle();
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("sb_left", sb.size(), 0);
        chk("accepts", n_acc_dut, n_acc_tb);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
